// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared RV32 load/store funct3 codes, controller FSM state
//               encoding and access-size helper for the data memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // RV32 load/store size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Number of bytes touched by an access; 0 marks an unknown code
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            F3_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_align
// Description : Combinational load formatter. Takes the four bytes starting at
//               the access address (byte 0 in bits [7:0]) and returns the
//               sign- or zero-extended RV32 load value selected by funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    // Extend the low lanes according to the access size and signedness
    always_comb begin
        o_data = 32'h0;
        case (i_funct3)
            F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_BU:   o_data = {24'h0, i_raw[7:0]};
            F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_HU:   o_data = {16'h0, i_raw[15:0]};
            F3_W:    o_data = i_raw;
            default: o_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Handshaked byte-addressable RV32 data memory. Accepts one
//               load/store at a time on a valid/ready request channel, applies
//               WAIT_STATES extra cycles, then holds the response until it is
//               consumed. Misaligned and illegal-funct3 accesses are faulted.
//               Optional macro DMEM_MISALIGN_EN: misaligned accesses are
//               performed bytewise (addresses wrap modulo the array size) and
//               only illegal funct3 codes fault.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int         DEPTH_BYTES = 1 << ADDR_W;
    localparam logic [2:0] c_WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t            r_state;
    logic [2:0]        r_wait_cnt;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic [2:0]        w_size;
    logic              w_legal;
    logic              w_misaligned;
    logic              w_fault;
    logic              w_accept;
    logic [ADDR_W-1:0] w_byte_addr [4];
    logic [31:0]       w_raw;
    logic [31:0]       w_load_data;

    // Classify the request: size, funct3 legality and alignment
    always_comb begin
        w_size  = size_bytes(req_funct3);
        // Unsigned codes (funct3[2]=1) exist only for loads
        w_legal = (w_size != 3'd0) && !(req_we && req_funct3[2]);
`ifdef DMEM_MISALIGN_EN
        w_misaligned = 1'b0;
`else
        w_misaligned = ((w_size == 3'd2) && req_addr[0]) ||
                       ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
`endif
        w_fault = !w_legal || w_misaligned;
    end

    // Four consecutive byte lanes; the address add wraps at the array end,
    // which only matters when misaligned accesses are allowed
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_byte_addr[k]    = req_addr + ADDR_W'(k);
            assign w_raw[8*k +: 8]   = r_mem[w_byte_addr[k]];
        end
    endgenerate

    dmem_load_align u_load_align (
        .i_raw    (w_raw),
        .i_funct3 (req_funct3),
        .o_data   (w_load_data)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Commit store lanes at the accepting edge; storage is never reset
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_size) begin
                    r_mem[w_byte_addr[k]] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Load data is captured now so later stores cannot alter it
                        rsp_rdata <= (req_we || w_fault) ? 32'h0 : w_load_data;
                        rsp_fault <= w_fault;
                        if (WAIT_STATES == 0) begin
                            r_state   <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= c_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed and reference-model bench for data_mem_ctrl. Three
//               instances: WAIT_STATES 0, 3 and 2 (index 0, 1, 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

`ifdef DMEM_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [7:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [2:0]  req_funct3 [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_fault  [3];
    logic        busy       [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] model [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            data_mem_ctrl #(
                .ADDR_W      (8),
                .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n[g]),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_we     (req_we[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .req_funct3 (req_funct3[g]),
                .rsp_valid  (rsp_valid[g]),
                .rsp_ready  (rsp_ready[g]),
                .rsp_rdata  (rsp_rdata[g]),
                .rsp_fault  (rsp_fault[g]),
                .busy       (busy[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction; returns response, latency and accept cycle
    task automatic access(input int d, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          output logic [31:0] rd, output logic flt,
                          output int lat, output int acc_cyc);
        int guard;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_funct3[d] = f3;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("req_ready timeout", {31'b0, req_ready[d]}, 32'd1);
        @(negedge clk);
        acc_cyc      = cyc;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) chk("rsp_valid timeout", {31'b0, rsp_valid[d]}, 32'd1);
        rd  = rsp_rdata[d];
        flt = rsp_fault[d];
    endtask

    task automatic xfer(input int d, input string tag, input bit we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_flt);
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          ac;
        access(d, we, addr, wdata, f3, rd, flt, lat, ac);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " fault"}, {31'b0, flt}, {31'b0, exp_flt});
        chk({tag, " latency"}, lat, ws_of(d) + 1);
    endtask

    // Byte-array reference: updates the model and predicts the response
    task automatic ref_access(input int d, input bit we, input logic [7:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              output logic [31:0] rd, output logic flt);
        int          sz;
        bit          legal;
        bit          mis;
        logic [31:0] raw;
        logic [7:0]  a;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        legal = (sz != 0) && !(we && f3 >= 3'd4);
        mis   = !MIS && (((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'b00)));
        flt   = !legal || mis;
        rd    = 32'h0;
        raw   = 32'h0;
        if (!flt) begin
            for (int k = 0; k < 4; k++) begin
                a = addr + 8'(k);
                if (we && k < sz) model[d][a] = wdata[8*k +: 8];
                raw[8*k +: 8] = model[d][a];
            end
            if (!we) begin
                case (f3)
                    3'd0:    rd = {{24{raw[7]}}, raw[7:0]};
                    3'd4:    rd = {24'h0, raw[7:0]};
                    3'd1:    rd = {{16{raw[15]}}, raw[15:0]};
                    3'd5:    rd = {16'h0, raw[15:0]};
                    default: rd = raw;
                endcase
            end
        end
    endtask

    task automatic random_run(input int d, input int n_ops);
        logic [31:0] rd, erd, wd;
        logic        flt, eflt;
        logic [7:0]  addr;
        logic [2:0]  f3;
        bit          we;
        int          lat, ac, prev;
        // Fill the whole array so every later load has a known answer
        for (int a = 0; a < 256; a += 4) begin
            wd = $urandom;
            ref_access(d, 1'b1, 8'(a), wd, 3'd2, erd, eflt);
            access(d, 1'b1, 8'(a), wd, 3'd2, rd, flt, lat, prev);
        end
        for (int i = 0; i < n_ops; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            ref_access(d, we, addr, wd, f3, erd, eflt);
            access(d, we, addr, wd, f3, rd, flt, lat, ac);
            chk($sformatf("rnd%0d #%0d rdata", d, i), rd, erd);
            chk($sformatf("rnd%0d #%0d fault", d, i), {31'b0, flt}, {31'b0, eflt});
            chk($sformatf("rnd%0d #%0d latency", d, i), lat, ws_of(d) + 1);
            chk($sformatf("rnd%0d #%0d spacing", d, i), ac - prev, ws_of(d) + 2);
            prev = ac;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int d = 0; d < 3; d++) begin
            rst_n[d]      = 1'b0;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 8'h0;
            req_wdata[d]  = 32'h0;
            req_funct3[d] = 3'd0;
            rsp_ready[d]  = 1'b1;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d req_ready", d), {31'b0, req_ready[d]}, 32'd1);
            chk($sformatf("reset%0d rsp_valid", d), {31'b0, rsp_valid[d]}, 32'd0);
            chk($sformatf("reset%0d rsp_rdata", d), rsp_rdata[d], 32'h0);
            chk($sformatf("reset%0d rsp_fault", d), {31'b0, rsp_fault[d]}, 32'd0);
            chk($sformatf("reset%0d busy", d), {31'b0, busy[d]}, 32'd0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Basic loads/stores, zero wait states
        xfer(0, "sw 10",  1'b1, 8'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
        xfer(0, "lw 10",  1'b0, 8'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);
        xfer(0, "lb 13",  1'b0, 8'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 1'b0);
        xfer(0, "lbu 13", 1'b0, 8'h13, 32'h0, 3'd4, 32'h000000DE, 1'b0);
        xfer(0, "lh 12",  1'b0, 8'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 1'b0);
        xfer(0, "lhu 10", 1'b0, 8'h10, 32'h0, 3'd5, 32'h0000BEEF, 1'b0);

        // Misalignment and illegal funct3
        xfer(0, "sw 14",  1'b1, 8'h14, 32'h00000000, 3'd2, 32'h0, 1'b0);
        xfer(0, "sw 20",  1'b1, 8'h20, 32'h11223344, 3'd2, 32'h0, 1'b0);
        xfer(0, "lw 11",  1'b0, 8'h11, 32'h0, 3'd2, MIS ? 32'h00DEADBE : 32'h0, !MIS);
        xfer(0, "sh 21",  1'b1, 8'h21, 32'h0000FFFF, 3'd1, 32'h0, !MIS);
        xfer(0, "lw 20a", 1'b0, 8'h20, 32'h0, 3'd2, MIS ? 32'h11FFFF44 : 32'h11223344, 1'b0);
        xfer(0, "ld f011", 1'b0, 8'h20, 32'h0, 3'd3, 32'h0, 1'b1);
        xfer(0, "st f100", 1'b1, 8'h20, 32'h0, 3'd4, 32'h0, 1'b1);
        xfer(0, "lw 20b", 1'b0, 8'h20, 32'h0, 3'd2, MIS ? 32'h11FFFF44 : 32'h11223344, 1'b0);

        // Top-of-array word access: wraps when misalignment is allowed
        xfer(0, "sw 00",  1'b1, 8'h00, 32'h0, 3'd2, 32'h0, 1'b0);
        xfer(0, "sw FC",  1'b1, 8'hFC, 32'h0, 3'd2, 32'h0, 1'b0);
        xfer(0, "sw FE",  1'b1, 8'hFE, 32'h11223344, 3'd2, 32'h0, !MIS);
        xfer(0, "lbu FE", 1'b0, 8'hFE, 32'h0, 3'd4, MIS ? 32'h44 : 32'h0, 1'b0);
        xfer(0, "lbu FF", 1'b0, 8'hFF, 32'h0, 3'd4, MIS ? 32'h33 : 32'h0, 1'b0);
        xfer(0, "lbu 00", 1'b0, 8'h00, 32'h0, 3'd4, MIS ? 32'h22 : 32'h0, 1'b0);
        xfer(0, "lbu 01", 1'b0, 8'h01, 32'h0, 3'd4, MIS ? 32'h11 : 32'h0, 1'b0);
        xfer(0, "lw FE",  1'b0, 8'hFE, 32'h0, 3'd2, MIS ? 32'h11223344 : 32'h0, !MIS);

        // Three wait states with the consumer stalling
        xfer(1, "ws3 sw 40", 1'b1, 8'h40, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0);
        @(negedge clk);
        rsp_ready[1]  = 1'b0;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_addr[1]   = 8'h40;
        req_funct3[1] = 3'd2;
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b1;
        req_wdata[1] = 32'h0;
        lat = 1;
        while (!rsp_valid[1] && lat < 50) begin
            chk("hold wait req_ready", {31'b0, req_ready[1]}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("hold latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d rsp_valid", i), {31'b0, rsp_valid[1]}, 32'd1);
            chk($sformatf("hold%0d rdata", i), rsp_rdata[1], 32'hCAFEF00D);
            chk($sformatf("hold%0d fault", i), {31'b0, rsp_fault[1]}, 32'd0);
            chk($sformatf("hold%0d req_ready", i), {31'b0, req_ready[1]}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        req_we[1]    = 1'b0;
        @(negedge clk);
        chk("release req_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("release busy", {31'b0, busy[1]}, 32'd0);
        chk("release rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        xfer(1, "ws3 lw 40", 1'b0, 8'h40, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT after a committed byte store
        @(negedge clk);
        req_valid[2]  = 1'b1;
        req_we[2]     = 1'b1;
        req_addr[2]   = 8'h05;
        req_wdata[2]  = 32'h000000A5;
        req_funct3[2] = 3'd0;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("rst busy before", {31'b0, busy[2]}, 32'd1);
        rst_n[2] = 1'b0;
        #1;
        chk("rst busy async", {31'b0, busy[2]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst held%0d rsp_valid", i), {31'b0, rsp_valid[2]}, 32'd0);
        end
        rst_n[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst post%0d rsp_valid", i), {31'b0, rsp_valid[2]}, 32'd0);
            chk($sformatf("rst post%0d req_ready", i), {31'b0, req_ready[2]}, 32'd1);
        end
        xfer(2, "ws2 lbu 05", 1'b0, 8'h05, 32'h0, 3'd4, 32'h000000A5, 1'b0);

        // Back-to-back random traffic against the reference model
        random_run(0, 30);
        random_run(1, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
